math_game_ctrl: RTL and testbench

Parametrised round controller for the mental-arithmetic game. It generates NUM_OPS pseudo-random operands from a seeded LFSR and shows each one for a fixed number of slow ticks. It then opens an answer window, checks the player's submitted sum against the internally accumulated total, and keeps a saturating score. It sits between the board switches/buttons and the LED/7-segment display drivers, and supersedes the fixed 5-operand, 5-bit sequencer.

---
 rtl/math_game_pkg.sv | 44 ++++
 rtl/math_game_ctrl_lfsr.sv | 35 +++
 rtl/math_game_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_math_game_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/math_game_pkg.sv
// Shared definitions for the mental-arithmetic round controller.
//   phase_t      : FSM state encoding, also driven out on the phase port
//   BCD_W        : width of one BCD display digit
//   tap_mask()   : Fibonacci LFSR feedback taps for widths 4..8
//   bcd_clamp999(): binary to three BCD digits, saturating at 999
package math_game_pkg;

  typedef enum logic [2:0] {
    PH_IDLE   = 3'd0,
    PH_SHOW   = 3'd1,
    PH_BLANK  = 3'd2,
    PH_ANSWER = 3'd3,
    PH_RESULT = 3'd4
  } phase_t;

  localparam int BCD_W   = 4;
  localparam int BCD_MAX = 999;

  // Maximal-length taps; bit i set means state bit i feeds the XOR.
  function automatic logic [7:0] tap_mask(input int w);
    case (w)
      4:       tap_mask = 8'b0000_1100;
      5:       tap_mask = 8'b0001_0100;
      6:       tap_mask = 8'b0011_0000;
      7:       tap_mask = 8'b0110_0000;
      8:       tap_mask = 8'b1011_1000;
      default: tap_mask = 8'b0000_0000;
    endcase
  endfunction

  // Returns {hundreds, tens, units}; anything above 999 shows as 999.
  function automatic logic [3*BCD_W-1:0] bcd_clamp999(input logic [31:0] v);
    logic [9:0]       c;
    logic [BCD_W-1:0] h;
    logic [BCD_W-1:0] t;
    logic [BCD_W-1:0] u;
    c = (v > 32'(BCD_MAX)) ? 10'(BCD_MAX) : v[9:0];
    h = BCD_W'(c / 10'd100);
    t = BCD_W'((c / 10'd10) % 10'd10);
    u = BCD_W'(c % 10'd10);
    return {h, t, u};
  endfunction

endpackage

// File: rtl/math_game_ctrl_lfsr.sv
// lfsr_param: W-bit Fibonacci LFSR, shifting left, taps from tap_mask(W).
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset, state returns to 1
//   load  : load seed (a zero seed loads 1 so the register never locks up)
//   seed  : value for load
//   step  : advance one position (load wins when both are high)
//   state : current register contents, never zero
module lfsr_param
  import math_game_pkg::*;
#(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] seed,
  input  logic         step,
  output logic [W-1:0] state
);

  localparam logic [7:0]   TAPS8 = tap_mask(W);
  localparam logic [W-1:0] TAPS  = TAPS8[W-1:0];
  localparam logic [W-1:0] ONE   = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ONE;
    end else if (load) begin
      state <= (seed == '0) ? ONE : seed;
    end else if (step) begin
      state <= {state[W-2:0], ^(state & TAPS)};
    end
  end

endmodule

// File: rtl/math_game_ctrl.sv
// math_game_ctrl: round controller for the mental-arithmetic game.
// Shows NUM_OPS pseudo-random operands, blanks the display, opens an answer
// window, compares the submitted sum with the accumulated total and keeps a
// saturating 4-bit score.
//   clk, rst       : clock, synchronous active-high reset
//   seed           : LFSR seed, taken when a start is accepted
//   start          : begin a round (only honoured in IDLE)
//   answer, submit : player's sum and its one-cycle commit pulse
//   disp_value     : value for the display (operand / 0 / answer / sum)
//   phase, busy    : FSM state and "not IDLE"
//   correct, score : last round result, count of correct rounds
//   bcd_*          : BCD digits of disp_value, clamped to 999
// Build option: define MATH_GAME_TIMEOUT_EN to end the answer window after
// ANSWER_TICKS ticks without a submit (scored as incorrect).
module math_game_ctrl
  import math_game_pkg::*;
#(
  parameter int NUM_OPS      = 5,
  parameter int OP_W         = 5,
  parameter int ANS_W        = 8,
  parameter int TICK_DIV     = 10,
  parameter int SHOW_TICKS   = 1,
  parameter int BLANK_TICKS  = 1,
  parameter int RESULT_TICKS = 4,
  parameter int ANSWER_TICKS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  seed,
  input  logic             start,
  input  logic [ANS_W-1:0] answer,
  input  logic             submit,
  output logic [ANS_W-1:0] disp_value,
  output logic [2:0]       phase,
  output logic             busy,
  output logic             correct,
  output logic [3:0]       score,
  output logic [3:0]       bcd_hundreds,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_units
);

  localparam int MAX_SUM = NUM_OPS * ((1 << OP_W) - 1);

  if (ANS_W < $clog2(MAX_SUM + 1) || ANS_W > 32) begin : g_ans_w_check
    $error("math_game_ctrl: ANS_W cannot hold the largest possible sum");
  end
  if (NUM_OPS < 2 || NUM_OPS > 15 || OP_W < 4 || OP_W > 8 || TICK_DIV < 2 ||
      SHOW_TICKS < 1 || BLANK_TICKS < 1 || RESULT_TICKS < 1 || ANSWER_TICKS < 1)
  begin : g_param_check
    $error("math_game_ctrl: parameter out of range");
  end

  localparam int PRE_W  = $clog2(TICK_DIV);
  localparam int OPI_W  = $clog2(NUM_OPS);
  localparam int TMAX_A = (SHOW_TICKS > BLANK_TICKS) ? SHOW_TICKS : BLANK_TICKS;
  localparam int TMAX_B = (RESULT_TICKS > ANSWER_TICKS) ? RESULT_TICKS : ANSWER_TICKS;
  localparam int TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
  localparam int TCNT_W = $clog2(TMAX + 1);

  phase_t           state_q;
  phase_t           state_d;
  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  logic [TCNT_W-1:0] tcnt;
  logic [OPI_W-1:0] op_idx;
  logic [ANS_W-1:0] sum;
  logic [OP_W-1:0]  lfsr;
  logic             correct_q;
  logic [3:0]       score_q;
  logic             match;

  logic             accept;
  logic             lfsr_step;
  logic             tcnt_clr;
  logic             tcnt_inc;
  logic             evaluate;
  logic             time_out;

  assign tick  = (pre_cnt == PRE_W'(TICK_DIV - 1));
  assign match = (answer == sum);

  lfsr_param #(.W(OP_W)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .seed  (seed),
    .step  (lfsr_step),
    .state (lfsr)
  );

  // Next-state and control strobes. tcnt counts slow ticks within a phase.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    lfsr_step = 1'b0;
    tcnt_clr  = 1'b0;
    tcnt_inc  = 1'b0;
    evaluate  = 1'b0;
    time_out  = 1'b0;
    case (state_q)
      PH_IDLE: begin
        if (start) begin
          accept   = 1'b1;
          tcnt_clr = 1'b1;
          state_d  = PH_SHOW;
        end
      end
      PH_SHOW: begin
        if (tick) begin
          if (tcnt == TCNT_W'(SHOW_TICKS - 1)) begin
            lfsr_step = 1'b1;
            tcnt_clr  = 1'b1;
            if (op_idx == OPI_W'(NUM_OPS - 1)) state_d = PH_BLANK;
          end else begin
            tcnt_inc = 1'b1;
          end
        end
      end
      PH_BLANK: begin
        if (tick) begin
          if (tcnt == TCNT_W'(BLANK_TICKS - 1)) begin
            tcnt_clr = 1'b1;
            state_d  = PH_ANSWER;
          end else begin
            tcnt_inc = 1'b1;
          end
        end
      end
      PH_ANSWER: begin
        // A submit arriving on the timeout tick is still scored.
        if (submit) begin
          evaluate = 1'b1;
          tcnt_clr = 1'b1;
          state_d  = PH_RESULT;
        end
`ifdef MATH_GAME_TIMEOUT_EN
        else if (tick) begin
          if (tcnt == TCNT_W'(ANSWER_TICKS - 1)) begin
            time_out = 1'b1;
            tcnt_clr = 1'b1;
            state_d  = PH_RESULT;
          end else begin
            tcnt_inc = 1'b1;
          end
        end
`endif
      end
      PH_RESULT: begin
        if (tick) begin
          if (tcnt == TCNT_W'(RESULT_TICKS - 1)) begin
            tcnt_clr = 1'b1;
            state_d  = PH_IDLE;
          end else begin
            tcnt_inc = 1'b1;
          end
        end
      end
      default: state_d = PH_IDLE;
    endcase
  end

  // Control registers: state, prescaler, tick/operand counters, result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= PH_IDLE;
      pre_cnt   <= '0;
      tcnt      <= '0;
      op_idx    <= '0;
      correct_q <= 1'b0;
      score_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      pre_cnt <= (accept || tick) ? '0 : pre_cnt + PRE_W'(1);
      if (tcnt_clr)      tcnt <= '0;
      else if (tcnt_inc) tcnt <= tcnt + TCNT_W'(1);
      if (accept)         op_idx <= '0;
      else if (lfsr_step) op_idx <= op_idx + OPI_W'(1);
      if (evaluate)                         correct_q <= match;
      else if (time_out || state_d == PH_IDLE) correct_q <= 1'b0;
      if (evaluate && match && score_q != 4'hF) score_q <= score_q + 4'd1;
    end
  end

  // Running total; cleared on each accepted start, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept)         sum <= '0;
    else if (lfsr_step) sum <= sum + ANS_W'(lfsr);
  end

  always_comb begin
    disp_value = '0;
    case (state_q)
      PH_SHOW:   disp_value = ANS_W'(lfsr);
      PH_ANSWER: disp_value = answer;
      PH_RESULT: disp_value = sum;
      default:   disp_value = '0;
    endcase
  end

  assign phase   = state_q;
  assign busy    = (state_q != PH_IDLE);
  assign correct = correct_q;
  assign score   = score_q;
  assign {bcd_hundreds, bcd_tens, bcd_units} = bcd_clamp999(32'(disp_value));

endmodule

// File: tb/tb_math_game_ctrl.sv
// Randomized self-checking bench for math_game_ctrl: a default-parameter
// instance plus a wide instance (15 operands of 8 bits, 12-bit answers).
module tb_math_game_ctrl;

  localparam int TD = 10, NOPS = 5, OPW = 5, ST = 1, BT = 1, RT = 4, AT = 8;
  localparam int TD2 = 2, NOPS2 = 15, OPW2 = 8, RT2 = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  seed;
  logic        start;
  logic [7:0]  answer;
  logic        submit;
  logic [7:0]  disp_value;
  logic [2:0]  phase;
  logic        busy, correct;
  logic [3:0]  score, bcd_h, bcd_t, bcd_u;

  logic [7:0]  seed2;
  logic        start2, submit2;
  logic [11:0] answer2, disp2;
  logic [2:0]  phase2;
  logic        busy2, correct2;
  logic [3:0]  score2, bcd2_h, bcd2_t, bcd2_u;

  int checks = 0, errors = 0, cyc = 0, mscore = 0, mscore2 = 0;

  math_game_ctrl dut (
    .clk(clk), .rst(rst), .seed(seed), .start(start), .answer(answer),
    .submit(submit), .disp_value(disp_value), .phase(phase), .busy(busy),
    .correct(correct), .score(score), .bcd_hundreds(bcd_h), .bcd_tens(bcd_t),
    .bcd_units(bcd_u)
  );

  math_game_ctrl #(
    .NUM_OPS(NOPS2), .OP_W(OPW2), .ANS_W(12), .TICK_DIV(TD2), .SHOW_TICKS(1),
    .BLANK_TICKS(1), .RESULT_TICKS(RT2), .ANSWER_TICKS(8)
  ) dut2 (
    .clk(clk), .rst(rst), .seed(seed2), .start(start2), .answer(answer2),
    .submit(submit2), .disp_value(disp2), .phase(phase2), .busy(busy2),
    .correct(correct2), .score(score2), .bcd_hundreds(bcd2_h), .bcd_tens(bcd2_t),
    .bcd_units(bcd2_u)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reference LFSR: shift left, new LSB is the parity of the tapped bits.
  function automatic int lfsr_next(input int w, input int s);
    int mask;
    case (w)
      4:       mask = 'h0C;
      5:       mask = 'h14;
      6:       mask = 'h30;
      7:       mask = 'h60;
      default: mask = 'hB8;
    endcase
    return ((s << 1) & ((1 << w) - 1)) | ($countones(s & mask) % 2);
  endfunction

  task automatic check_bcd(input string tag, input int v,
                           input logic [3:0] h, input logic [3:0] t, input logic [3:0] u);
    int c;
    c = (v > 999) ? 999 : v;
    check({tag, "_h"}, h, c / 100);
    check({tag, "_t"}, t, (c / 10) % 10);
    check({tag, "_u"}, u, c % 10);
  endtask

  // Submit ans (or skip when timed_out), check the result and its hold time.
  task automatic finish_round(input int ans, input int sum, input int t0, input bit timed_out);
    int ts, n, dur;
    bit ok;
    if (!timed_out) begin
      answer = 8'(ans);
      submit = 1'b1;
      step();
      submit = 1'b0;
    end
    ts = cyc;
    ok = !timed_out && (ans == sum);
    if (ok && mscore < 15) mscore++;
    check("res_phase", phase, 4);
    check("res_correct", correct, ok);
    check("res_score", score, mscore);
    check("res_disp", disp_value, sum);
    check_bcd("res_bcd", sum, bcd_h, bcd_t, bcd_u);
    dur = RT * TD - ((ts - t0) % TD);
    n = 0;
    while (phase == 3'd4 && n < 200) begin
      step();
      n++;
    end
    check("res_len", n, dur);
    check("idle_phase", phase, 0);
    check("idle_disp", disp_value, 0);
    check("idle_busy", busy, 0);
    check("idle_correct", correct, 0);
  endtask

  // mode: 0 correct, 1 wrong, 2 stray start/submit in SHOW, 3 no submit,
  // 4 submit on the timeout tick.
  task automatic run_round(input int sd, input int mode);
    int ops[NOPS];
    int s, sum, t0, w;
    s = (sd == 0) ? 1 : sd;
    sum = 0;
    for (int i = 0; i < NOPS; i++) begin
      ops[i] = s;
      sum += s;
      s = lfsr_next(OPW, s);
    end
    seed = 5'(sd);
    start = 1'b1;
    step();
    start = 1'b0;
    t0 = cyc;
    for (int i = 0; i < NOPS; i++) begin
      for (int c = 0; c < ST * TD; c++) begin
        check("show_phase", phase, 1);
        check("show_op", disp_value, ops[i]);
        if (mode == 2 && c == 3) begin
          start  = 1'b1;
          submit = 1'b1;
          seed   = 5'($urandom);
          answer = 8'(sum);
        end
        step();
        start  = 1'b0;
        submit = 1'b0;
      end
    end
    for (int c = 0; c < BT * TD; c++) begin
      check("blank_phase", phase, 2);
      check("blank_disp", disp_value, 0);
      step();
    end
    check("answer_phase", phase, 3);
    if (mode <= 2) begin
      w = $urandom_range(1, 20);
      for (int k = 0; k < w; k++) begin
        answer = 8'($urandom);
        step();
        check("answer_live", disp_value, answer);
      end
      check_bcd("answer_bcd", int'(answer), bcd_h, bcd_t, bcd_u);
      finish_round((mode == 1) ? sum - 1 : sum, sum, t0, 1'b0);
    end else begin
`ifdef MATH_GAME_TIMEOUT_EN
      answer = 8'(sum);
      if (mode == 3) begin
        w = 0;
        while (phase == 3'd3 && w < 200) begin
          step();
          w++;
        end
        check("timeout_len", w, AT * TD);
        finish_round(sum, sum, t0, 1'b1);
      end else begin
        for (int k = 0; k < AT * TD - 1; k++) step();
        check("pre_timeout_phase", phase, 3);
        finish_round(sum, sum, t0, 1'b0);
      end
`else
      for (int k = 0; k < 100; k++) step();
      check("no_timeout_phase", phase, 3);
      finish_round(sum, sum, t0, 1'b0);
`endif
    end
  endtask

  task automatic run_round2(input int sd, input bit good);
    int ops[NOPS2];
    int bvals[5] = '{0, 998, 999, 1000, 4095};
    int s, sum, t0, ts, n, ans;
    s = (sd == 0) ? 1 : sd;
    sum = 0;
    for (int i = 0; i < NOPS2; i++) begin
      ops[i] = s;
      sum += s;
      s = lfsr_next(OPW2, s);
    end
    seed2 = 8'(sd);
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    t0 = cyc;
    for (int i = 0; i < NOPS2; i++) begin
      for (int c = 0; c < TD2; c++) begin
        check("w_show_op", disp2, ops[i]);
        step();
      end
    end
    for (int c = 0; c < TD2; c++) begin
      check("w_blank_disp", disp2, 0);
      step();
    end
    check("w_answer_phase", phase2, 3);
    foreach (bvals[k]) begin
      answer2 = 12'(bvals[k]);
      step();
      check("w_answer_live", disp2, bvals[k]);
      check_bcd("w_answer_bcd", bvals[k], bcd2_h, bcd2_t, bcd2_u);
    end
    ans = good ? sum : sum + 1;
    answer2 = 12'(ans);
    submit2 = 1'b1;
    step();
    submit2 = 1'b0;
    ts = cyc;
    if (good && mscore2 < 15) mscore2++;
    check("w_res_phase", phase2, 4);
    check("w_res_correct", correct2, good);
    check("w_res_score", score2, mscore2);
    check("w_res_disp", disp2, sum);
    check_bcd("w_res_bcd", sum, bcd2_h, bcd2_t, bcd2_u);
    n = 0;
    while (phase2 == 3'd4 && n < 100) begin
      step();
      n++;
    end
    check("w_res_len", n, RT2 * TD2 - ((ts - t0) % TD2));
    check("w_idle_phase", phase2, 0);
  endtask

  initial begin
    int sd;
    rst = 1'b1; seed = '0; start = 1'b0; answer = '0; submit = 1'b0;
    seed2 = '0; start2 = 1'b0; answer2 = '0; submit2 = 1'b0;
    for (int k = 0; k < 3; k++) step();
    check("rst_phase", phase, 0);
    check("rst_disp", disp_value, 0);
    check("rst_busy", busy, 0);
    check("rst_correct", correct, 0);
    check("rst_score", score, 0);
    check_bcd("rst_bcd", 0, bcd_h, bcd_t, bcd_u);
    check("rst_phase2", phase2, 0);
    check("rst_score2", score2, 0);
    rst = 1'b0;
    step();

    run_round(1, 0);
    run_round(1, 1);
    run_round(0, 2);

    // Reset in the middle of the fourth operand, then replay the same seed.
    sd = $urandom_range(1, 31);
    seed = 5'(sd);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 3 * TD + 2; k++) step();
    check("mid_show_phase", phase, 1);
    rst = 1'b1;
    step();
    check("midrst_phase", phase, 0);
    check("midrst_disp", disp_value, 0);
    check("midrst_busy", busy, 0);
    check("midrst_score", score, 0);
    rst = 1'b0;
    mscore = 0;
    run_round(sd, 0);

    run_round(3, 3);
`ifdef MATH_GAME_TIMEOUT_EN
    run_round(5, 4);
`endif

    for (int r = 0; r < 17; r++) run_round($urandom_range(0, 31), 0);
    check("score_saturated", score, 15);
    for (int r = 0; r < 4; r++) run_round($urandom_range(0, 31), $urandom_range(0, 1));

    run_round2(1, 1'b1);
    run_round2($urandom_range(0, 255), 1'b0);
    for (int r = 0; r < 2; r++) run_round2($urandom_range(0, 255), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
